// File: rtl/mm_pkg.sv
// ---------------------------------------------------------------------------
// mm_pkg
// Definitions shared by the matrix multiplier (top / avalon_wrapper) and the
// result drain that reads C back out.
//   accWidth   : width of one C element (product width plus growth over K)
//   addrWidthC : width of a C BRAM address covering M*N elements
//   drainState_e : IDLE / ARMED / DRAIN states of c_result_drain
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
package mm_pkg;

    // A sum of K products of two DATA_WIDTH operands grows by clog2(K) bits.
    // K=1 still reserves one guard bit so the width never collapses.
    function automatic int accWidth(input int dataWidth, input int k);
        return 2 * dataWidth + ((k > 1) ? $clog2(k) : 1);
    endfunction

    // A single-element C still needs a one-bit address port.
    function automatic int addrWidthC(input int m, input int n);
        return ((m * n) > 1) ? $clog2(m * n) : 1;
    endfunction

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ARMED = 2'd1,
        DRAIN = 2'd2
    } drainState_e;

endpackage

// File: rtl/sync_fifo.sv
// ---------------------------------------------------------------------------
// sync_fifo
// Single-clock first-word-fall-through FIFO. The head entry is visible on
// dout whenever the FIFO is non-empty; dout reads as zero when empty.
// Ports:
//   clk, rst      : clock, synchronous active-high reset (empties the FIFO)
//   push, din     : write din when push (accepted when not full, or when a
//                   pop frees a slot in the same cycle)
//   pop, dout     : drop the head entry when pop and not empty
//   full, empty   : registered status flags
//   count         : number of stored entries (0..DEPTH)
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module sync_fifo #(
    parameter  int WIDTH = 8,
    parameter  int DEPTH = 4,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] din,
    input  logic             pop,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty,
    output logic [AW:0]      count
);

    localparam logic [AW:0] FULL_COUNT = (AW + 1)'(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wrPtr;
    logic [AW-1:0]    r_rdPtr;
    logic [AW:0]      r_count;
    logic             r_full;
    logic             r_empty;

    logic             w_doPush;
    logic             w_doPop;
    logic [AW:0]      w_countNext;

    assign w_doPop  = pop && !r_empty;
    assign w_doPush = push && (!r_full || w_doPop);

    // Occupancy only changes when exactly one of push/pop takes effect.
    always_comb begin
        w_countNext = r_count;
        if (w_doPush && !w_doPop) begin
            w_countNext = r_count + (AW + 1)'(1);
        end else if (w_doPop && !w_doPush) begin
            w_countNext = r_count - (AW + 1)'(1);
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two. The flags are
    // registered from the next count so they carry no decode logic.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wrPtr <= '0;
            r_rdPtr <= '0;
            r_count <= '0;
            r_full  <= 1'b0;
            r_empty <= 1'b1;
        end else begin
            if (w_doPush) begin
                r_wrPtr <= r_wrPtr + AW'(1);
            end
            if (w_doPop) begin
                r_rdPtr <= r_rdPtr + AW'(1);
            end
            r_count <= w_countNext;
            r_full  <= (w_countNext == FULL_COUNT);
            r_empty <= (w_countNext == '0);
        end
    end

    // Storage is left unreset; the empty flag masks stale contents.
    always_ff @(posedge clk) begin
        if (w_doPush) begin
            r_mem[r_wrPtr] <= din;
        end
    end

    assign dout  = r_empty ? '0 : r_mem[r_rdPtr];
    assign full  = r_full;
    assign empty = r_empty;
    assign count = r_count;

endmodule

// File: rtl/c_result_drain.sv
// ---------------------------------------------------------------------------
// c_result_drain
// Streams the M*N elements of C out of the multiplier's C BRAM in row-major
// order once a multiplication finishes. Reads are issued only while the
// output FIFO has room for every outstanding element, so consumer
// backpressure never drops data.
// Ports:
//   clk, rst            : clock, synchronous active-high reset
//   start               : one-cycle pulse arming a drain (ignored unless IDLE)
//   mult_done           : level from the multiplier; starts the drain in ARMED
//   read_en_c           : C BRAM read enable
//   read_addr_c         : C BRAM read address
//   dout_c              : C BRAM data, valid one cycle after read_en_c
//   out_valid/out_ready : element stream handshake
//   out_data, out_last  : element C[addr]; last marks element M*N-1
//   busy                : high in ARMED or DRAIN
//   done                : one-cycle pulse after the final element transfers
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module c_result_drain
    import mm_pkg::*;
#(
    parameter  int DATA_WIDTH   = 16,
    parameter  int M            = 3,
    parameter  int K            = 3,
    parameter  int N            = 3,
    parameter  int FIFO_DEPTH   = 4,
    localparam int ACC_WIDTH    = accWidth(DATA_WIDTH, K),
    localparam int ADDR_WIDTH_C = addrWidthC(M, N)
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start,
    input  logic                    mult_done,
    output logic                    read_en_c,
    output logic [ADDR_WIDTH_C-1:0] read_addr_c,
    input  logic [ACC_WIDTH-1:0]    dout_c,
    output logic                    out_valid,
    output logic [ACC_WIDTH-1:0]    out_data,
    output logic                    out_last,
    input  logic                    out_ready,
    output logic                    busy,
    output logic                    done
);

    localparam int NUM_ELEMS = M * N;
    // Counters must be able to hold NUM_ELEMS itself, one past the last address.
    localparam int CNT_W     = $clog2(NUM_ELEMS + 1);
    localparam int FIFO_CW   = $clog2(FIFO_DEPTH) + 1;
    localparam logic [CNT_W-1:0] LAST_IDX  = CNT_W'(NUM_ELEMS - 1);
    localparam logic [CNT_W-1:0] ALL_ELEMS = CNT_W'(NUM_ELEMS);

    drainState_e          r_state;
    logic [CNT_W-1:0]     r_issued;
    logic [CNT_W-1:0]     r_xferCount;
    logic                 r_inflight;
    logic                 r_inflightLast;
    logic                 r_busy;
    logic                 r_done;

    logic                 w_readEn;
    logic                 w_credit;
    logic                 w_pop;
    logic                 w_fifoFull;
    logic                 w_fifoEmpty;
    logic [FIFO_CW-1:0]   w_fifoCount;
    logic [ACC_WIDTH:0]   w_fifoDout;

    // A read may only be issued if the FIFO can absorb it together with the
    // read already in flight from the previous cycle.
    assign w_credit  = (int'(w_fifoCount) + int'(r_inflight)) < FIFO_DEPTH;
    assign w_readEn  = (r_state == DRAIN) && (r_issued < ALL_ELEMS) && w_credit;
    assign w_pop     = !w_fifoEmpty && out_ready;

    assign read_en_c   = w_readEn;
    assign read_addr_c = r_issued[ADDR_WIDTH_C-1:0];

    // Control FSM together with the issue/transfer counters and the
    // registered status outputs. The in-flight marker is the previous
    // cycle's read enable, so BRAM data is pushed exactly when it lands.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state        <= IDLE;
            r_issued       <= '0;
            r_xferCount    <= '0;
            r_inflight     <= 1'b0;
            r_inflightLast <= 1'b0;
            r_busy         <= 1'b0;
            r_done         <= 1'b0;
        end else begin
            r_done         <= 1'b0;
            r_inflight     <= w_readEn;
            r_inflightLast <= w_readEn && (r_issued == LAST_IDX);
            unique case (r_state)
                IDLE: begin
                    if (start) begin
                        r_state <= ARMED;
                        r_busy  <= 1'b1;
                    end
                end
                ARMED: begin
                    if (mult_done) begin
                        r_state     <= DRAIN;
                        r_issued    <= '0;
                        r_xferCount <= '0;
                    end
                end
                DRAIN: begin
                    if (w_readEn) begin
                        r_issued <= r_issued + CNT_W'(1);
                    end
                    if (w_pop) begin
                        r_xferCount <= r_xferCount + CNT_W'(1);
                        if (r_xferCount == LAST_IDX) begin
                            r_state <= IDLE;
                            r_busy  <= 1'b0;
                            r_done  <= 1'b1;
                        end
                    end
                end
                default: begin
                    r_state <= IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    // Each entry carries its last flag alongside the data word.
    sync_fifo #(
        .WIDTH (ACC_WIDTH + 1),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (r_inflight),
        .din   ({r_inflightLast, dout_c}),
        .pop   (w_pop),
        .dout  (w_fifoDout),
        .full  (w_fifoFull),
        .empty (w_fifoEmpty),
        .count (w_fifoCount)
    );

    assign out_valid = !w_fifoEmpty;
    assign out_last  = w_fifoDout[ACC_WIDTH];
    assign out_data  = w_fifoDout[ACC_WIDTH-1:0];
    assign busy      = r_busy;
    assign done      = r_done;

    // The credit rule must make overflow impossible, and the stream's last
    // flag must agree with the transfer counter.
    always_ff @(posedge clk) begin
        if (!rst) begin
            assert (!(r_inflight && w_fifoFull));
            if (w_pop) begin
                assert (out_last == (r_xferCount == LAST_IDX));
            end
        end
    end

endmodule
